// File: rtl/img_enh_pkg.sv
// -----------------------------------------------------------------------------
// img_enh_pkg
// Shared types and constants for the image-enhancement (sharpening) blocks.
//   state_e    : frame sequencer states (IDLE/LOAD/FLUSH/DONE)
//   IMG_*_DEF  : default frame geometry
//   cnt_width  : width needed for the row/column counters of a given geometry
// -----------------------------------------------------------------------------
package img_enh_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int IMG_W_DEF = 128;
    localparam int IMG_H_DEF = 128;

    // Bits needed to hold max(w,h); this also covers the largest index max(w,h)-1.
    function automatic int cnt_width(input int w, input int h);
        int m;
        m = (w > h) ? w : h;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(IMG_W_DEF, IMG_H_DEF);

endpackage

// File: rtl/sharpen_pos_cnt.sv
// -----------------------------------------------------------------------------
// sharpen_pos_cnt
// Row-major pixel position counter. It advances the column on each enable and
// wraps the column into the row. The row wraps at the end of the frame, so the
// counter is back at (0,0) once a whole frame has been counted.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : synchronous clear to (0,0); has priority over en_i
//   en_i      : advance one position
//   row_o     : current row
//   col_o     : current column
//   last_o    : position is (H-1, W-1)
// -----------------------------------------------------------------------------
module sharpen_pos_cnt #(
    parameter int W     = 4,
    parameter int H     = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] row_o,
    output logic [CNT_W-1:0] col_o,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(H - 1);

    logic [CNT_W-1:0] row_d, row_q;
    logic [CNT_W-1:0] col_d, col_q;
    logic             col_end;
    logic             row_end;

    assign col_end = (col_q == COL_MAX);
    assign row_end = (row_q == ROW_MAX);

    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: state registers take non-blocking assignments only; the combinational
    // block above uses blocking ones. Mixing them leads to simulation/synthesis mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = col_end & row_end;

endmodule

// File: rtl/sharpen_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sharpen_frame_ctrl
// Frame sequencer for the streaming 3x3 sharpening datapath. It accepts one
// row-major pixel stream per frame and gates the line-buffer shifts. It then
// pushes IMG_W+1 zero samples to flush the window, and it tracks the output
// pixel position so it can raise the border-pad flags.
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : begin a frame (sampled in IDLE only)
//   pix_valid_i     : source has a pixel
//   pix_ready_o     : pixel accepted this cycle when valid (LOAD only)
//   out_ready_i     : sink can take a sharpened pixel
//   lb_shift_o      : shift line buffers / window by one sample
//   lb_zero_o       : shifted sample is forced to zero (flush tail)
//   win_valid_o     : window centred on (out_row_o, out_col_o) is complete
//   out_row_o/col_o : position of the pixel being emitted
//   pad_*_o         : zero the matching kernel taps (valid with win_valid_o)
//   busy_o          : frame in progress (LOAD/FLUSH/DONE)
//   done_o          : one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module sharpen_frame_ctrl
    import img_enh_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CNT_W = cnt_width(IMG_W, IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    input  logic             out_ready_i,
    output logic             lb_shift_o,
    output logic             lb_zero_o,
    output logic             win_valid_o,
    output logic [CNT_W-1:0] out_row_o,
    output logic [CNT_W-1:0] out_col_o,
    output logic             pad_top_o,
    output logic             pad_bot_o,
    output logic             pad_lft_o,
    output logic             pad_rgt_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] in_row, in_col;
    logic             in_last;
    logic             out_last;
    logic             emit;
    logic             frame_clr;
    logic             in_adv;

    // The window for output 0 is complete on sample index IMG_W+1, which is
    // input position (1,1). During LOAD the input position is the sample
    // index, so emit is any position at or beyond (1,1). Every FLUSH sample
    // lies past that point, so emit is always set in FLUSH.
    assign emit = (state_q == FLUSH) ||
                  ((state_q == LOAD) &&
                   ((in_row > ONE) || ((in_row == ONE) && (in_col != '0))));

    assign frame_clr   = (state_q == IDLE) && start_i;
    assign in_adv      = lb_shift_o && (state_q == LOAD);
    assign win_valid_o = lb_shift_o && emit;

    always_comb begin
        state_d     = state_q;
        pix_ready_o = 1'b0;
        lb_shift_o  = 1'b0;
        lb_zero_o   = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = LOAD;
            end
            LOAD: begin
                busy_o      = 1'b1;
                // Before the first emit there is no output to stall on.
                pix_ready_o = out_ready_i || !emit;
                lb_shift_o  = pix_valid_i && pix_ready_o;
                if (lb_shift_o && in_last) state_d = FLUSH;
            end
            FLUSH: begin
                busy_o     = 1'b1;
                lb_zero_o  = 1'b1;
                lb_shift_o = out_ready_i;
                if (win_valid_o && out_last) state_d = DONE;
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the reset is asynchronous and returns the sequencer to IDLE at once.
    // An abandoned frame never reaches DONE, so it produces no done_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    sharpen_pos_cnt #(.W(IMG_W), .H(IMG_H), .CNT_W(CNT_W)) u_in_pos (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (frame_clr),
        .en_i   (in_adv),
        .row_o  (in_row),
        .col_o  (in_col),
        .last_o (in_last)
    );

    sharpen_pos_cnt #(.W(IMG_W), .H(IMG_H), .CNT_W(CNT_W)) u_out_pos (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (frame_clr),
        .en_i   (win_valid_o),
        .row_o  (out_row_o),
        .col_o  (out_col_o),
        .last_o (out_last)
    );

    assign pad_top_o = win_valid_o && (out_row_o == '0);
    assign pad_bot_o = win_valid_o && (out_row_o == ROW_MAX);
    assign pad_lft_o = win_valid_o && (out_col_o == '0);
    assign pad_rgt_o = win_valid_o && (out_col_o == COL_MAX);

endmodule

// File: tb/tb_sharpen_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sharpen_frame_ctrl
// Directed bench for sharpen_frame_ctrl on a 4x4 frame. A hand-computed vector
// table covers reset, start, the first emit and a LOAD stall. Frame-level runs
// then compare every cycle against a sample-index reference model. They also
// check the per-frame totals for bubbles, a flush stall, a mid-frame reset and
// start_i held high.
// -----------------------------------------------------------------------------
module tb_sharpen_frame_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int CW   = 3;
    localparam int NPIX = W * H;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_FLUSH = 2;
    localparam int M_DONE  = 3;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_BUBBLE = 1;
    localparam int MODE_FSTALL = 2;
    localparam int MODE_HOLD   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, pix_valid_i, out_ready_i;
    logic          pix_ready_o, lb_shift_o, lb_zero_o, win_valid_o;
    logic [CW-1:0] out_row_o, out_col_o;
    logic          pad_top_o, pad_bot_o, pad_lft_o, pad_rgt_o;
    logic          busy_o, done_o;

    sharpen_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .pix_valid_i (pix_valid_i),
        .pix_ready_o (pix_ready_o),
        .out_ready_i (out_ready_i),
        .lb_shift_o  (lb_shift_o),
        .lb_zero_o   (lb_zero_o),
        .win_valid_o (win_valid_o),
        .out_row_o   (out_row_o),
        .out_col_o   (out_col_o),
        .pad_top_o   (pad_top_o),
        .pad_bot_o   (pad_bot_o),
        .pad_lft_o   (pad_lft_o),
        .pad_rgt_o   (pad_rgt_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: frame state and sample index.
    int m_state = M_IDLE;
    int m_n     = 0;

    // Per-frame totals observed on the DUT outputs.
    int acc_cnt, zero_cnt, wv_cnt, done_cnt;

    // Packed output word:
    // {pr, shift, zero, wv, row[2:0], col[2:0], top, bot, lft, rgt, busy, done}
    typedef struct {
        logic        start;
        logic        pv;
        logic        ordy;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [15:0] mk(input logic pr, sh, zr, wv, input int row, col,
                                       input logic [3:0] pad, input logic busy, done);
        logic [2:0] r, c;
        r = 3'(row);
        c = 3'(col);
        return {pr, sh, zr, wv, r, c, pad, busy, done};
    endfunction

    function automatic logic [15:0] dut_word();
        return {pix_ready_o, lb_shift_o, lb_zero_o, win_valid_o, out_row_o, out_col_o,
                pad_top_o, pad_bot_o, pad_lft_o, pad_rgt_o, busy_o, done_o};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs derived from the sample index (shifts so far this frame).
    function automatic logic [15:0] model_exp(input logic pv, input logic ordy);
        logic emit, pr, sh, zr, wv;
        int e;
        int row, col;
        logic [3:0] pad;
        emit = (m_state == M_FLUSH) || ((m_state == M_LOAD) && (m_n >= W + 1));
        pr   = (m_state == M_LOAD) && (ordy || !emit);
        sh   = (m_state == M_LOAD)  ? (pv && pr) :
               (m_state == M_FLUSH) ? ordy : 1'b0;
        zr   = (m_state == M_FLUSH);
        wv   = sh && emit;
        e    = m_n - (W + 1);
        if (e < 0) e = 0;
        e    = e % NPIX;
        row  = e / W;
        col  = e % W;
        pad  = wv ? {row == 0, row == H - 1, col == 0, col == W - 1} : 4'b0000;
        return mk(pr, sh, zr, wv, row, col, pad, m_state != M_IDLE, m_state == M_DONE);
    endfunction

    task automatic model_step(input logic st, pv, ordy);
        case (m_state)
            M_IDLE: if (st) begin
                m_state = M_LOAD;
                m_n     = 0;
            end
            M_LOAD: if (pv && (ordy || m_n < W + 1)) begin
                m_n++;
                if (m_n == NPIX) m_state = M_FLUSH;
            end
            M_FLUSH: if (ordy) begin
                m_n++;
                if (m_n == NPIX + W + 1) m_state = M_DONE;
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic clear_totals();
        acc_cnt  = 0;
        zero_cnt = 0;
        wv_cnt   = 0;
        done_cnt = 0;
    endtask

    // Drive at posedge+1, compare at negedge, advance the model at the next posedge.
    task automatic cycle(input logic st, pv, ordy, input string name, output logic [15:0] act);
        logic [15:0] exp;
        start_i     = st;
        pix_valid_i = pv;
        out_ready_i = ordy;
        @(negedge clk);
        exp = model_exp(pv, ordy);
        act = dut_word();
        check(name, act, exp);
        if (pix_valid_i && pix_ready_o)  acc_cnt++;
        if (lb_shift_o && lb_zero_o)     zero_cnt++;
        if (win_valid_o)                 wv_cnt++;
        if (done_o)                      done_cnt++;
        @(posedge clk);
        model_step(st, pv, ordy);
        #1;
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_accepted"}, 16'(acc_cnt), 16'(NPIX));
        check({tag, "_zero_shifts"}, 16'(zero_cnt), 16'(W + 1));
        check({tag, "_win_valid"}, 16'(wv_cnt), 16'(NPIX));
        check({tag, "_done_pulses"}, 16'(done_cnt), 16'd1);
    endtask

    // Run until the frame returns to IDLE after done_o (bounded).
    task automatic run_frame(input int mode, input bit do_start, input string tag);
        int cyc = 0;
        int fc  = 0;
        bit seen_done = 1'b0;
        logic st, pv, ordy;
        logic [15:0] act;
        while (!(seen_done && m_state == M_IDLE) && cyc < 300) begin
            st   = (mode == MODE_HOLD) ? 1'b1 : (do_start && cyc == 0);
            pv   = (mode == MODE_BUBBLE) ? (cyc % 2 == 0) : 1'b1;
            ordy = 1'b1;
            if (mode == MODE_FSTALL && m_state == M_FLUSH) begin
                ordy = (fc >= 3);
                fc++;
            end
            cycle(st, pv, ordy, tag, act);
            if (act[0]) seen_done = 1'b1;
            cyc++;
        end
        check({tag, "_done_seen"}, {15'b0, seen_done}, 16'd1);
    endtask

    initial begin
        logic [15:0] act;

        // Hand-computed vectors: reset/idle, start, first emit, LOAD stall.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0)};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0)};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 4'b0000, 1, 0)};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 4'b0000, 1, 0)};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 4'b0000, 1, 0)};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 4'b0000, 1, 0)};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 4'b0000, 1, 0)};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 0, 1, 0, 0, 4'b1010, 1, 0)};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 1, 4'b0000, 1, 0)};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 1, 4'b0000, 1, 0)};
        tbl[10] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 4'b0000, 1, 0)};
        tbl[11] = '{1'b0, 1'b1, 1'b1, mk(1, 1, 0, 1, 0, 1, 4'b1000, 1, 0)};
        tbl[12] = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 2, 4'b0000, 1, 0)};
        tbl[13] = '{1'b0, 1'b1, 1'b1, mk(1, 1, 0, 1, 0, 2, 4'b1000, 1, 0)};

        rst = 1'b1;
        start_i = 1'b0;
        pix_valid_i = 1'b0;
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", dut_word(), 16'h0000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame 1: table prefix, then the rest back-to-back.
        clear_totals();
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].start, tbl[i].pv, tbl[i].ordy, $sformatf("model_vec%0d", i), act);
            check($sformatf("table_vec%0d", i), act, tbl[i].exp);
        end
        run_frame(MODE_NORMAL, 1'b0, "f1");
        check_totals("f1");

        // Frame 2: pixel bubbles every other cycle.
        clear_totals();
        run_frame(MODE_BUBBLE, 1'b1, "f2_bubble");
        check_totals("f2_bubble");

        // Frame 3: sink stalls for the first three FLUSH cycles.
        clear_totals();
        run_frame(MODE_FSTALL, 1'b1, "f3_fstall");
        check_totals("f3_fstall");

        // Frame 4: asynchronous reset after the 9th accepted pixel.
        clear_totals();
        cycle(1'b1, 1'b0, 1'b1, "f4_start", act);
        for (int i = 0; i < 40 && acc_cnt < 9; i++) cycle(1'b0, 1'b1, 1'b1, "f4_load", act);
        check("f4_nine_accepted", 16'(acc_cnt), 16'd9);
        #2 rst = 1'b1;
        #1 check("f4_async_reset_outputs", dut_word(), 16'h0000);
        m_state = M_IDLE;
        m_n     = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("f4_no_done_on_abort", 16'(done_cnt), 16'd0);
        clear_totals();
        run_frame(MODE_NORMAL, 1'b1, "f5_after_reset");
        check_totals("f5_after_reset");

        // Frame 6: start_i held high through the frame and beyond.
        clear_totals();
        run_frame(MODE_HOLD, 1'b1, "f6_hold");
        check_totals("f6_hold");
        cycle(1'b1, 1'b1, 1'b1, "f6_restart_idle", act);
        check("f6_idle_not_busy", {15'b0, act[1]}, 16'd0);
        cycle(1'b1, 1'b1, 1'b1, "f6_restart_load", act);
        check("f6_second_frame_busy", {15'b0, act[1]}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
